mcu_core_mc: RTL

Parametrised multi-cycle successor of the single-cycle Harvard processor top. It sequences fetch/decode/execute/memory through an explicit FSM, so external memories need not be combinational. The data memory sits behind a req/ack handshake. The block adds a bounded hardware stack with error flag, NPORTS output ports, and halt/resume.

---
 rtl/mcu_core_mc_if.sv | 32 +++
 rtl/mcu_core_mc.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_core_mc_if.sv
// mcu_core_mc_if -- data-memory request/acknowledge bus of the multi-cycle core.
//
// Signals:
//   dmem_req    core -> mem  request; held high until the ack cycle
//   dmem_we     core -> mem  1 = write, 0 = read
//   dmem_addr   core -> mem  word address (DADDR_W bits)
//   dmem_wdata  core -> mem  write data (DATA_W bits)
//   dmem_rdata  mem -> core  read data, valid in the ack cycle
//   dmem_ack    mem -> core  completes the request; ignored while dmem_req=0
//
// Modports: master = the core, slave = the memory / responder.
interface mcu_core_mc_if #(
  parameter int DATA_W  = 32,
  parameter int DADDR_W = 11
);
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mcu_core_mc.sv
// mcu_core_mc -- multi-cycle Harvard core.
//
// Each instruction walks FETCH -> DECODE -> EXEC (3 cycles); loads, stores,
// PUSH and POP add a MEM phase that waits for the data-memory acknowledge.
// Also provides a bounded hardware stack with a sticky error flag, NPORTS
// output ports and a HALT state left through the resume input.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   imem_addr   instruction address (= pc)
//   imem_rdata  instruction word, valid in the same cycle (async ROM)
//   bus         data-memory handshake (mcu_core_mc_if.master); the interface
//               instance must use the same DATA_W / DADDR_W as this core
//   resume      leaves HALT, continuing at the following instruction
//   port_out    output ports, port k = bits [k*PORT_W +: PORT_W]
//   flags       {C,S,Z}
//   halted      high while in HALT
//   stk_err     sticky stack overflow / underflow
module mcu_core_mc #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 10,
  parameter int RA_W      = 3,
  parameter int DADDR_W   = 11,
  parameter int STK_BASE  = 1024,
  parameter int STK_DEPTH = 16,
  parameter int NPORTS    = 2,
  parameter int PORT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [31:0]              imem_rdata,
  mcu_core_mc_if.master            bus,
  input  logic                     resume,
  output logic [NPORTS*PORT_W-1:0] port_out,
  output logic [2:0]               flags,
  output logic                     halted,
  output logic                     stk_err
);

  localparam int NREG = 1 << RA_W;
  localparam int SP_W = $clog2(STK_DEPTH + 1);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_PUSH = 4'h9;
  localparam logic [3:0] OP_POP  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [DADDR_W-1:0] STK_BASE_A = DADDR_W'(STK_BASE);
  localparam logic [SP_W-1:0]    SP_FULL    = SP_W'(STK_DEPTH);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t                     state_r, state_s;
  logic [PC_W-1:0]            pc_r, pc_s;
  logic [31:0]                ir_r;
  logic [DATA_W-1:0]          a_r, b_r;
  logic [NREG-1:0][DATA_W-1:0] regs_r;
  logic [SP_W-1:0]            sp_r;
  logic [2:0]                 flags_r;
  logic [NPORTS*PORT_W-1:0]   port_out_r;
  logic                       halted_r;
  logic                       stk_err_r;
  logic                       dmem_req_r;
  logic                       dmem_we_r;
  logic [DADDR_W-1:0]         dmem_addr_r;
  logic [DATA_W-1:0]          dmem_wdata_r;

  // Decoded instruction fields; only the low RA_W bits of register fields count.
  logic [3:0]         op_s;
  logic [RA_W-1:0]    rd_s, rs1_s, rs2_s;
  logic [15:0]        imm_s;
  logic [DATA_W-1:0]  simm_s;
  logic               unused_ir_s;

  assign op_s   = ir_r[31:28];
  assign rd_s   = ir_r[24 +: RA_W];
  assign rs1_s  = ir_r[20 +: RA_W];
  assign rs2_s  = ir_r[16 +: RA_W];
  assign imm_s  = ir_r[15:0];
  assign simm_s = {{(DATA_W-16){imm_s[15]}}, imm_s};
  // High register-field bits are don't-care for small RA_W.
  assign unused_ir_s = ^ir_r;

  // ALU result, carry and "this op updates rd/flags" indication.
  logic [DATA_W:0]   add_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_c_s;
  logic              alu_op_s;

  // Combinational ALU for ops 1..6.
  always_comb begin
    add_s     = '0;
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_op_s  = 1'b0;
    case (op_s)
      OP_ADD, OP_ADDI: begin
        add_s     = {1'b0, a_r} + {1'b0, ((op_s == OP_ADDI) ? simm_s : b_r)};
        alu_res_s = add_s[DATA_W-1:0];
        alu_c_s   = add_s[DATA_W];
        alu_op_s  = 1'b1;
      end
      OP_SUB: begin
        alu_res_s = a_r - b_r;
        alu_c_s   = (a_r < b_r);
        alu_op_s  = 1'b1;
      end
      OP_AND: begin
        alu_res_s = a_r & b_r;
        alu_op_s  = 1'b1;
      end
      OP_OR: begin
        alu_res_s = a_r | b_r;
        alu_op_s  = 1'b1;
      end
      OP_XOR: begin
        alu_res_s = a_r ^ b_r;
        alu_op_s  = 1'b1;
      end
      default: begin
        alu_op_s = 1'b0;
      end
    endcase
  end

  // Memory-class decode, stack bound check and data address.
  logic               mem_op_s;
  logic               stk_fault_s;
  logic [DADDR_W-1:0] ea_s;
  logic [DADDR_W-1:0] daddr_s;
  logic               jmp_take_s;

  assign mem_op_s    = (op_s == OP_LD) || (op_s == OP_ST) ||
                       (op_s == OP_PUSH) || (op_s == OP_POP);
  assign stk_fault_s = ((op_s == OP_PUSH) && (sp_r == SP_FULL)) ||
                       ((op_s == OP_POP) && (sp_r == '0));
  assign ea_s        = a_r[DADDR_W-1:0] + simm_s[DADDR_W-1:0];

  // Data address mux: POP reads the slot below SP, PUSH writes the slot at SP.
  always_comb begin
    daddr_s = ea_s;
    case (op_s)
      OP_PUSH: daddr_s = STK_BASE_A + DADDR_W'(sp_r);
      OP_POP:  daddr_s = STK_BASE_A + DADDR_W'(sp_r) - DADDR_W'(1);
      default: daddr_s = ea_s;
    endcase
  end

  // Branch condition evaluated against the flags left by earlier ALU ops.
  always_comb begin
    jmp_take_s = 1'b0;
    case (op_s)
      OP_JMP:  jmp_take_s = 1'b1;
      OP_JZ:   jmp_take_s = flags_r[0];
      OP_JC:   jmp_take_s = flags_r[2];
      default: jmp_take_s = 1'b0;
    endcase
  end

  // Next-state and next-pc logic of the sequencer.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    case (state_r)
      ST_FETCH:  state_s = ST_DECODE;
      ST_DECODE: state_s = ST_EXEC;
      ST_EXEC: begin
        if (op_s == OP_HLT) begin
          state_s = ST_HALT;
        end else if (mem_op_s && !stk_fault_s) begin
          // pc advances only once the memory access completes
          state_s = ST_MEM;
        end else if (jmp_take_s) begin
          state_s = ST_FETCH;
          pc_s    = imm_s[PC_W-1:0];
        end else begin
          state_s = ST_FETCH;
          pc_s    = pc_r + PC_W'(1);
        end
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          state_s = ST_FETCH;
          pc_s    = pc_r + PC_W'(1);
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_s = ST_FETCH;
          pc_s    = pc_r + PC_W'(1);
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_FETCH;
      end
    endcase
  end

  // Sequencer state and program counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FETCH;
      pc_r    <= '0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
    end
  end

  // Instruction register and operand latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_r <= '0;
      a_r  <= '0;
      b_r  <= '0;
    end else if (state_r == ST_FETCH) begin
      ir_r <= imem_rdata;
    end else if (state_r == ST_DECODE) begin
      a_r <= regs_r[rs1_s];
      b_r <= regs_r[rs2_s];
    end
  end

  // Register-file write port: ALU results in EXEC, load/pop data on ack.
  logic              rf_we_s;
  logic [DATA_W-1:0] rf_wd_s;

  // Register-file write select.
  always_comb begin
    rf_we_s = 1'b0;
    rf_wd_s = alu_res_s;
    if ((state_r == ST_EXEC) && alu_op_s) begin
      rf_we_s = 1'b1;
    end else if ((state_r == ST_MEM) && bus.dmem_ack &&
                 ((op_s == OP_LD) || (op_s == OP_POP))) begin
      rf_we_s = 1'b1;
      rf_wd_s = bus.dmem_rdata;
    end else begin
      rf_we_s = 1'b0;
    end
  end

  // Register file; r0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_r <= '0;
    end else if (rf_we_s && (rd_s != '0)) begin
      regs_r[rd_s] <= rf_wd_s;
    end
  end

  // Flags, output ports, halt indicator and sticky stack error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_r    <= 3'b000;
      port_out_r <= '0;
      halted_r   <= 1'b0;
      stk_err_r  <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      if (alu_op_s) begin
        flags_r <= {alu_c_s, alu_res_s[DATA_W-1], (alu_res_s == '0)};
      end
      if (op_s == OP_OUT) begin
        // port indices at or beyond NPORTS match nothing and act as NOP
        for (int k = 0; k < NPORTS; k++) begin
          if (imm_s == 16'(k)) begin
            port_out_r[k*PORT_W +: PORT_W] <= a_r[PORT_W-1:0];
          end
        end
      end
      if (op_s == OP_HLT) begin
        halted_r <= 1'b1;
      end
      if (stk_fault_s) begin
        stk_err_r <= 1'b1;
      end
    end else if ((state_r == ST_HALT) && resume) begin
      halted_r <= 1'b0;
    end
  end

  // Data-memory request: raised leaving EXEC, held stable until the ack cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= '0;
      dmem_wdata_r <= '0;
    end else if ((state_r == ST_EXEC) && mem_op_s && !stk_fault_s) begin
      dmem_req_r   <= 1'b1;
      dmem_we_r    <= (op_s == OP_ST) || (op_s == OP_PUSH);
      dmem_addr_r  <= daddr_s;
      dmem_wdata_r <= b_r;
    end else if ((state_r == ST_MEM) && bus.dmem_ack) begin
      dmem_req_r <= 1'b0;
      dmem_we_r  <= 1'b0;
    end
  end

  // Stack pointer moves only when the stack access is acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_r <= '0;
    end else if ((state_r == ST_MEM) && bus.dmem_ack) begin
      if (op_s == OP_PUSH) begin
        sp_r <= sp_r + SP_W'(1);
      end else if (op_s == OP_POP) begin
        sp_r <= sp_r - SP_W'(1);
      end
    end
  end

  assign imem_addr      = pc_r;
  assign port_out       = port_out_r;
  assign flags          = flags_r;
  assign halted         = halted_r;
  assign stk_err        = stk_err_r;
  assign bus.dmem_req   = dmem_req_r;
  assign bus.dmem_we    = dmem_we_r;
  assign bus.dmem_addr  = dmem_addr_r;
  assign bus.dmem_wdata = dmem_wdata_r;

endmodule
